// File: rtl/alu_arbiter.sv
// Round-robin arbiter and sequencer for the shared 32-bit ALU: two requesters,
// one transaction in flight, results returned on per-requester response channels.
module alu_arbiter #(
  parameter int unsigned PRIORITY_RESET = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_0,
  input  logic        req_valid_1,
  output logic        req_ready_0,
  output logic        req_ready_1,
  input  logic [31:0] req_a_0,
  input  logic [31:0] req_a_1,
  input  logic [31:0] req_b_0,
  input  logic [31:0] req_b_1,
  input  logic [3:0]  req_ctrl_0,
  input  logic [3:0]  req_ctrl_1,
  output logic        rsp_valid_0,
  output logic        rsp_valid_1,
  input  logic        rsp_ready_0,
  input  logic        rsp_ready_1,
  output logic [31:0] rsp_y,
  output logic        rsp_zero,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_control,
  input  logic [31:0] alu_y,
  input  logic        alu_zero,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic PRIO_INIT = (PRIORITY_RESET != 0);

  state_e      state_q, state_d;
  logic        prio_q, prio_d;
  logic        owner_q, owner_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] y_q, y_d;
  logic        zero_q, zero_d;

  logic        winner;
  logic        win_valid;
  logic        accept;
  logic        rsp_fire;

  // A lone valid requester wins outright; the pointer only breaks ties.
  always_comb begin
    winner = prio_q;
    if (req_valid_0 && !req_valid_1) begin
      winner = 1'b0;
    end else if (req_valid_1 && !req_valid_0) begin
      winner = 1'b1;
    end
    win_valid = winner ? req_valid_1 : req_valid_0;
    accept    = (state_q == IDLE) && win_valid;
    rsp_fire  = (state_q == RESP) && (owner_q ? rsp_ready_1 : rsp_ready_0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)   state_d = EXEC;
      EXEC:                  state_d = RESP;
      RESP:    if (rsp_fire) state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  always_comb begin
    prio_d  = prio_q;
    owner_d = owner_q;
    a_d     = a_q;
    b_d     = b_q;
    ctrl_d  = ctrl_q;
    y_d     = y_q;
    zero_d  = zero_q;
    if (accept) begin
      owner_d = winner;
      a_d     = winner ? req_a_1    : req_a_0;
      b_d     = winner ? req_b_1    : req_b_0;
      ctrl_d  = winner ? req_ctrl_1 : req_ctrl_0;
    end
    if (state_q == EXEC) begin
      y_d    = alu_y;
      zero_d = alu_zero;
    end
    if (rsp_fire) begin
      prio_d = ~owner_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q  <= PRIO_INIT;
      owner_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      ctrl_q  <= '0;
      y_q     <= '0;
      zero_q  <= 1'b0;
    end else begin
      prio_q  <= prio_d;
      owner_q <= owner_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ctrl_q  <= ctrl_d;
      y_q     <= y_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    req_ready_0 = (state_q == IDLE) && !winner;
    req_ready_1 = (state_q == IDLE) && winner;
    rsp_valid_0 = (state_q == RESP) && !owner_q;
    rsp_valid_1 = (state_q == RESP) && owner_q;
    busy        = (state_q != IDLE);
    alu_a       = a_q;
    alu_b       = b_q;
    alu_control = ctrl_q;
    rsp_y       = y_q;
    rsp_zero    = zero_q;
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus a randomized
// transaction loop checked against a transaction-level reference.
module tb_alu_arbiter;

  localparam int unsigned PRIO = 0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid_0 = 1'b0, req_valid_1 = 1'b0;
  logic        req_ready_0, req_ready_1;
  logic [31:0] req_a_0 = '0, req_a_1 = '0, req_b_0 = '0, req_b_1 = '0;
  logic [3:0]  req_ctrl_0 = '0, req_ctrl_1 = '0;
  logic        rsp_valid_0, rsp_valid_1;
  logic        rsp_ready_0 = 1'b0, rsp_ready_1 = 1'b0;
  logic [31:0] rsp_y;
  logic        rsp_zero;
  logic [31:0] alu_a, alu_b, alu_y;
  logic [3:0]  alu_control;
  logic        alu_zero;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic exp_prio;

  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] c);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return (a < b) ? 32'd1 : 32'd0;
      4'b1100: return ~(a | b);
      default: return 32'd0;
    endcase
  endfunction

  assign alu_y    = alu_ref(alu_a, alu_b, alu_control);
  assign alu_zero = (alu_y == 32'd0);

  alu_arbiter #(.PRIORITY_RESET(PRIO)) dut (
    .clk(clk), .rst(rst),
    .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
    .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
    .req_a_0(req_a_0), .req_a_1(req_a_1),
    .req_b_0(req_b_0), .req_b_1(req_b_1),
    .req_ctrl_0(req_ctrl_0), .req_ctrl_1(req_ctrl_1),
    .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1),
    .rsp_ready_0(rsp_ready_0), .rsp_ready_1(rsp_ready_1),
    .rsp_y(rsp_y), .rsp_zero(rsp_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_y(alu_y), .alu_zero(alu_zero),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit expired");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int p, input logic v, input logic [31:0] a,
                           input logic [31:0] b, input logic [3:0] c);
    if (p == 0) begin
      req_valid_0 = v; req_a_0 = a; req_b_0 = b; req_ctrl_0 = c;
    end else begin
      req_valid_1 = v; req_a_1 = a; req_b_1 = b; req_ctrl_1 = c;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_req(0, 1'b0, '0, '0, '0);
    drive_req(1, 1'b0, '0, '0, '0);
    rsp_ready_0 = 1'b0;
    rsp_ready_1 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_prio = (PRIO != 0);
  endtask

  // Single transaction on port p with the other port idle; returns what was observed.
  task automatic run_txn(input int p, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] c, output logic [1:0] rdy,
                         output logic [1:0] rv, output logic [31:0] y, output logic z);
    drive_req(p, 1'b1, a, b, c);
    if (p == 0) rsp_ready_0 = 1'b1; else rsp_ready_1 = 1'b1;
    #1;
    rdy = {req_ready_1, req_ready_0};
    step();
    drive_req(p, 1'b0, '0, '0, '0);
    step();
    rv = {rsp_valid_1, rsp_valid_0};
    y  = rsp_y;
    z  = rsp_zero;
    step();
    exp_prio = (p == 0);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if ({rsp_valid_1, rsp_valid_0} !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid got %b exp 00", {rsp_valid_1, rsp_valid_0}); end
    checks++; if ({alu_a, alu_b, alu_control} !== 68'd0) begin errors++; $display("FAIL reset_alu_drive got %h exp 0", {alu_a, alu_b, alu_control}); end
    checks++; if ({rsp_y, rsp_zero} !== 33'd0) begin errors++; $display("FAIL reset_rsp got %h exp 0", {rsp_y, rsp_zero}); end
    req_valid_1 = 1'b1; #1;
    checks++; if ({req_ready_1, req_ready_0} !== 2'b10) begin errors++; $display("FAIL reset_ready_only1 got %b exp 10", {req_ready_1, req_ready_0}); end
    req_valid_1 = 1'b0; req_valid_0 = 1'b1; #1;
    checks++; if ({req_ready_1, req_ready_0} !== 2'b01) begin errors++; $display("FAIL reset_ready_only0 got %b exp 01", {req_ready_1, req_ready_0}); end
    req_valid_1 = 1'b1; #1;
    checks++; if ({req_ready_1, req_ready_0} !== (exp_prio ? 2'b10 : 2'b01)) begin errors++; $display("FAIL reset_ready_both got %b exp prio %b", {req_ready_1, req_ready_0}, exp_prio); end
    req_valid_0 = 1'b0; req_valid_1 = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    drive_req(0, 1'b1, 32'd5, 32'd7, 4'b0010);
    rsp_ready_0 = 1'b1;
    #1;
    checks++; if ({req_ready_1, req_ready_0} !== 2'b01) begin errors++; $display("FAIL basic_ready got %b exp 01", {req_ready_1, req_ready_0}); end
    step();
    drive_req(0, 1'b0, '0, '0, '0);
    checks++; if ({busy, alu_a, alu_b, alu_control} !== {1'b1, 32'd5, 32'd7, 4'b0010}) begin errors++; $display("FAIL basic_exec got %h exp %h", {busy, alu_a, alu_b, alu_control}, {1'b1, 32'd5, 32'd7, 4'b0010}); end
    checks++; if ({rsp_valid_1, rsp_valid_0} !== 2'b00) begin errors++; $display("FAIL basic_exec_rsp_valid got %b exp 00", {rsp_valid_1, rsp_valid_0}); end
    step();
    checks++; if ({rsp_valid_1, rsp_valid_0} !== 2'b01) begin errors++; $display("FAIL basic_rsp_valid got %b exp 01", {rsp_valid_1, rsp_valid_0}); end
    checks++; if ({rsp_y, rsp_zero} !== {32'd12, 1'b0}) begin errors++; $display("FAIL basic_result got %h/%b exp 0000000c/0", rsp_y, rsp_zero); end
    step();
    checks++; if ({busy, rsp_valid_1, rsp_valid_0} !== 3'b000) begin errors++; $display("FAIL basic_done got %b exp 000", {busy, rsp_valid_1, rsp_valid_0}); end
    exp_prio = 1'b1;
  endtask

  task automatic test_alternation();
    int last;
    logic g;
    do_reset();
    drive_req(0, 1'b1, 32'd10, 32'd3, 4'b0110);
    drive_req(1, 1'b1, 32'hF0, 32'h0F, 4'b0001);
    rsp_ready_0 = 1'b1; rsp_ready_1 = 1'b1;
    last = 0;
    g = exp_prio;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if ({req_ready_1, req_ready_0} !== (g ? 2'b10 : 2'b01)) begin errors++; $display("FAIL alt_grant%0d got %b exp owner %b", i, {req_ready_1, req_ready_0}, g); end
      if (i > 0) begin
        checks++; if (cyc - last !== 3) begin errors++; $display("FAIL alt_spacing%0d got %0d exp 3", i, cyc - last); end
      end
      last = cyc;
      step();
      step();
      checks++; if ({rsp_valid_1, rsp_valid_0} !== (g ? 2'b10 : 2'b01)) begin errors++; $display("FAIL alt_rsp_port%0d got %b exp owner %b", i, {rsp_valid_1, rsp_valid_0}, g); end
      checks++; if (rsp_y !== (g ? 32'hFF : 32'd7)) begin errors++; $display("FAIL alt_rsp_y%0d got %h exp %h", i, rsp_y, (g ? 32'hFF : 32'd7)); end
      step();
      exp_prio = ~g;
      g = exp_prio;
    end
    drive_req(0, 1'b0, '0, '0, '0);
    drive_req(1, 1'b0, '0, '0, '0);
  endtask

  task automatic test_zero_sltu();
    logic [1:0] rdy, rv;
    logic [31:0] y;
    logic z;
    run_txn(1, 32'h1234, 32'h1234, 4'b0110, rdy, rv, y, z);
    checks++; if ({rdy, rv} !== 4'b1010) begin errors++; $display("FAIL sub_ports got %b exp 1010", {rdy, rv}); end
    checks++; if ({y, z} !== {32'd0, 1'b1}) begin errors++; $display("FAIL sub_zero got %h/%b exp 00000000/1", y, z); end
    run_txn(1, 32'd1, 32'hFFFF_FFFF, 4'b0111, rdy, rv, y, z);
    checks++; if ({y, z} !== {32'd1, 1'b0}) begin errors++; $display("FAIL sltu got %h/%b exp 00000001/0", y, z); end
  endtask

  task automatic test_backpressure();
    logic [31:0] y0;
    logic z0;
    rsp_ready_0 = 1'b0; rsp_ready_1 = 1'b1;
    drive_req(0, 1'b1, 32'hFFFF_0000, 32'h0000_00FF, 4'b0001);
    step();
    drive_req(0, 1'b0, '0, '0, '0);
    drive_req(1, 1'b1, 32'd9, 32'd4, 4'b0010);
    step();
    checks++; if ({rsp_valid_1, rsp_valid_0, rsp_y} !== {2'b01, 32'hFFFF_00FF}) begin errors++; $display("FAIL bp_first got %b/%h exp 01/ffff00ff", {rsp_valid_1, rsp_valid_0}, rsp_y); end
    y0 = 32'hFFFF_00FF;
    z0 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++; if ({rsp_valid_1, rsp_valid_0, rsp_y, rsp_zero, busy} !== {2'b01, y0, z0, 1'b1}) begin errors++; $display("FAIL bp_hold%0d got %b/%h/%b/%b exp 01/%h/%b/1", k, {rsp_valid_1, rsp_valid_0}, rsp_y, rsp_zero, busy, y0, z0); end
      checks++; if (req_ready_1 !== 1'b0) begin errors++; $display("FAIL bp_ready1_%0d got %b exp 0", k, req_ready_1); end
    end
    rsp_ready_0 = 1'b1;
    step();
    exp_prio = 1'b1;
    checks++; if ({busy, rsp_valid_0, req_ready_1} !== 3'b001) begin errors++; $display("FAIL bp_release got %b exp 001", {busy, rsp_valid_0, req_ready_1}); end
    checks++; if (rsp_y !== y0) begin errors++; $display("FAIL bp_y_after got %h exp %h", rsp_y, y0); end
    step();
    drive_req(1, 1'b0, '0, '0, '0);
    step();
    checks++; if ({rsp_valid_1, rsp_y} !== {1'b1, 32'd13}) begin errors++; $display("FAIL bp_second got %b/%h exp 1/0000000d", rsp_valid_1, rsp_y); end
    step();
    exp_prio = 1'b0;
  endtask

  task automatic test_bad_opcode();
    logic [1:0] rdy, rv;
    logic [31:0] y;
    logic z;
    run_txn(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1111, rdy, rv, y, z);
    checks++; if ({rv, y, z} !== {2'b01, 32'd0, 1'b1}) begin errors++; $display("FAIL bad_opcode got %b/%h/%b exp 01/00000000/1", rv, y, z); end
  endtask

  task automatic test_reset_mid();
    logic [1:0] rdy, rv;
    logic [31:0] y;
    logic z;
    logic seen;
    do_reset();
    run_txn(0, 32'h11, 32'h22, 4'b0010, rdy, rv, y, z);
    drive_req(1, 1'b1, 32'hDEAD_BEEF, 32'h1, 4'b0010);
    rsp_ready_1 = 1'b1;
    step();
    drive_req(1, 1'b0, '0, '0, '0);
    #2 rst = 1'b1;
    #1;
    checks++; if ({busy, rsp_valid_1, rsp_valid_0} !== 3'b000) begin errors++; $display("FAIL rstmid_ctrl got %b exp 000", {busy, rsp_valid_1, rsp_valid_0}); end
    checks++; if ({alu_a, alu_b, alu_control, rsp_y, rsp_zero} !== 101'd0) begin errors++; $display("FAIL rstmid_regs got %h exp 0", {alu_a, alu_b, alu_control, rsp_y, rsp_zero}); end
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k == 2) rst = 1'b0;
      step();
      seen = seen | rsp_valid_0 | rsp_valid_1 | busy;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rstmid_no_rsp got %b exp 0", seen); end
    exp_prio = (PRIO != 0);
    drive_req(0, 1'b1, 32'd40, 32'd2, 4'b0110);
    drive_req(1, 1'b1, 32'd3, 32'd3, 4'b0010);
    rsp_ready_0 = 1'b1; rsp_ready_1 = 1'b1;
    #1;
    checks++; if ({req_ready_1, req_ready_0} !== (exp_prio ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rstmid_prio got %b exp owner %b", {req_ready_1, req_ready_0}, exp_prio); end
    step();
    drive_req(0, 1'b0, '0, '0, '0);
    drive_req(1, 1'b0, '0, '0, '0);
    step();
    checks++; if ({rsp_valid_1, rsp_valid_0, rsp_y} !== (exp_prio ? {2'b10, 32'd6} : {2'b01, 32'd38})) begin errors++; $display("FAIL rstmid_fresh got %b/%h", {rsp_valid_1, rsp_valid_0}, rsp_y); end
    step();
    exp_prio = ~exp_prio;
  endtask

  task automatic test_random();
    logic        pend [2];
    logic [31:0] pa [2];
    logic [31:0] pb [2];
    logic [3:0]  pc [2];
    logic [3:0]  codes [8];
    logic [31:0] ey;
    logic [1:0]  oh;
    int w, n, p;
    codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b0011, 4'b1111};
    pend = '{1'b0, 1'b0};
    for (int it = 0; it < 40; it++) begin
      for (int q = 0; q < 2; q++) begin
        if (!pend[q] && $urandom_range(0, 1) == 1) begin
          pend[q] = 1'b1;
          pa[q] = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
          pb[q] = ($urandom_range(0, 3) == 0) ? pa[q] : $urandom;
          pc[q] = codes[$urandom_range(0, 7)];
        end
      end
      if (!pend[0] && !pend[1]) begin
        p = int'($urandom_range(0, 1));
        pend[p] = 1'b1; pa[p] = $urandom; pb[p] = $urandom; pc[p] = codes[$urandom_range(0, 7)];
      end
      for (int q = 0; q < 2; q++) drive_req(q, pend[q], pa[q], pb[q], pc[q]);
      w = (pend[0] && pend[1]) ? int'(exp_prio) : (pend[1] ? 1 : 0);
      oh = (w == 1) ? 2'b10 : 2'b01;
      rsp_ready_0 = 1'($urandom_range(0, 1));
      rsp_ready_1 = 1'($urandom_range(0, 1));
      if (w == 0) rsp_ready_0 = 1'b0; else rsp_ready_1 = 1'b0;
      #1;
      checks++; if ({req_ready_1, req_ready_0} !== oh) begin errors++; $display("FAIL rnd_grant%0d got %b exp %b", it, {req_ready_1, req_ready_0}, oh); end
      step();
      pend[w] = 1'b0;
      drive_req(w, 1'b0, '0, '0, '0);
      checks++; if ({busy, req_ready_1, req_ready_0, alu_a, alu_b, alu_control} !== {3'b100, pa[w], pb[w], pc[w]}) begin errors++; $display("FAIL rnd_exec%0d got %h exp %h", it, {busy, req_ready_1, req_ready_0, alu_a, alu_b, alu_control}, {3'b100, pa[w], pb[w], pc[w]}); end
      ey = alu_ref(pa[w], pb[w], pc[w]);
      n = int'($urandom_range(0, 3));
      for (int k = 0; k <= n; k++) begin
        step();
        checks++; if ({rsp_valid_1, rsp_valid_0, rsp_y, rsp_zero, req_ready_1, req_ready_0} !== {oh, ey, (ey == 32'd0), 2'b00}) begin errors++; $display("FAIL rnd_rsp%0d_%0d got %b/%h/%b exp %b/%h/%b", it, k, {rsp_valid_1, rsp_valid_0}, rsp_y, rsp_zero, oh, ey, (ey == 32'd0)); end
      end
      if (w == 0) rsp_ready_0 = 1'b1; else rsp_ready_1 = 1'b1;
      step();
      checks++; if ({busy, rsp_valid_1, rsp_valid_0} !== 3'b000) begin errors++; $display("FAIL rnd_done%0d got %b exp 000", it, {busy, rsp_valid_1, rsp_valid_0}); end
      exp_prio = (w == 0);
    end
    drive_req(0, 1'b0, '0, '0, '0);
    drive_req(1, 1'b0, '0, '0, '0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_alternation();
    test_zero_sltu();
    test_backpressure();
    test_bad_opcode();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
